pe_agu_sched: RTL

- Per-PE instruction scheduler sitting between the PE-group controller and the PE address-generation unit.
- Queues AGU instructions and tracks the ping-pong index buffer fill state.
- Issues switch_idx_buf / start to the AGU strictly in order, and waits on the AGU done level before issuing the next instruction.
- Guarantees the AGU never reads a half-written index buffer and the loader never overwrites the buffer the AGU is reading.

---
 rtl/pe_agu_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pe_agu_sched.sv
// pe_agu_sched
// Per-PE scheduler between the PE-group controller and the PE address
// generation unit. Instructions are queued in a small FIFO and issued to the
// AGU strictly in order. Each issue consumes one filled half of the ping-pong
// index buffer. The next instruction is not issued until the AGU reports done
// again.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   ins_data/valid/ready instruction push handshake (ready = queue not full)
//   idx_wr_done          loader pulse: write half of the index buffer is full
//   idx_wr_ready         write half is free for the loader
//   agu_start            one-cycle start pulse to the AGU
//   agu_switch_idx_buf   one-cycle ping-pong swap pulse (always precedes start)
//   agu_* fields         decoded fields of the issued instruction, held until
//                        the next swap
//   agu_done             AGU done level (1 = idle)
//   busy                 queue non-empty or an instruction in flight
//   ins_done_cnt         completed-instruction count (wraps)
module pe_agu_sched #(
  parameter int INS_DEPTH = 4,
  parameter int INS_W     = 24,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] ins_data,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic             idx_wr_done,
  output logic             idx_wr_ready,
  output logic             agu_start,
  output logic [1:0]       agu_mode,
  output logic [7:0]       agu_idx_cnt,
  output logic [7:0]       agu_trip_cnt,
  output logic             agu_is_new,
  output logic [3:0]       agu_pad_code,
  output logic             agu_cut_y,
  output logic             agu_switch_idx_buf,
  input  logic             agu_done,
  output logic             busy,
  output logic [CNT_W-1:0] ins_done_cnt
);

  localparam int PTR_W = $clog2(INS_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(INS_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWITCH,
    S_START,
    S_ARM,
    S_BUSY
  } state_t;

  state_t             state_reg;
  logic [INS_W-1:0]   mem [INS_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     occ_reg;
  logic               wr_full_reg;
  logic [INS_W-1:0]   ins_reg;
  logic               start_reg;
  logic               switch_reg;
  logic [CNT_W-1:0]   done_cnt_reg;
  logic               push;
  logic               pop;

  assign ins_ready    = (occ_reg < DEPTH_L);
  assign idx_wr_ready = ~wr_full_reg;
  assign push         = ins_valid && ins_ready;

  // The queue head is popped on the edge that enters SWITCH, so the fields
  // are already on the outputs during the swap cycle and are stable for a
  // full cycle before the start pulse.
  assign pop = (state_reg == S_IDLE) && (occ_reg != '0) && wr_full_reg && agu_done;

  assign busy = (occ_reg != '0) || (state_reg != S_IDLE);

  assign agu_start          = start_reg;
  assign agu_switch_idx_buf = switch_reg;
  assign ins_done_cnt       = done_cnt_reg;
  assign agu_mode           = ins_reg[1:0];
  assign agu_idx_cnt        = ins_reg[9:2];
  assign agu_trip_cnt       = ins_reg[17:10];
  assign agu_is_new         = ins_reg[18];
  assign agu_pad_code       = ins_reg[22:19];
  assign agu_cut_y          = ins_reg[23];

  // Queue storage: write port only, no reset, so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= ins_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      wr_full_reg  <= 1'b0;
      ins_reg      <= '0;
      start_reg    <= 1'b0;
      switch_reg   <= 1'b0;
      done_cnt_reg <= '0;
    end else begin
      start_reg  <= 1'b0;
      switch_reg <= 1'b0;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        ins_reg    <= mem[rd_ptr_reg];
      end
      occ_reg <= occ_reg + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

      // A load finishing in the swap cycle refills the freed half, so the
      // set takes priority over the clear. A load while already full is a
      // loader protocol error and simply leaves the flag set.
      if (idx_wr_done) begin
        wr_full_reg <= 1'b1;
      end else if (state_reg == S_SWITCH) begin
        wr_full_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            state_reg  <= S_SWITCH;
            switch_reg <= 1'b1;
          end
        end
        S_SWITCH: begin
          state_reg <= S_START;
          start_reg <= 1'b1;
        end
        S_START: begin
          state_reg <= S_ARM;
        end
        S_ARM: begin
          // agu_done still shows the pre-start idle level here.
          state_reg <= S_BUSY;
        end
        S_BUSY: begin
          if (agu_done) begin
            done_cnt_reg <= done_cnt_reg + CNT_W'(1);
            state_reg    <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
